// File: rtl/amp_seq_if.sv
// Control and status bundle between the register bank and the amplifier power sequencer.
`timescale 1ns/1ps
interface amp_seq_if;
  logic       ena;
  logic       start;
  logic       fault;
  logic       amp_nenable;
  logic       amp_mute;
  logic       i2s_clk_en;
  logic       ready;
  logic [2:0] state_mon;

  modport master (
    output ena, start, fault,
    input  amp_nenable, amp_mute, i2s_clk_en, ready, state_mon
  );

  modport slave (
    input  ena, start, fault,
    output amp_nenable, amp_mute, i2s_clk_en, ready, state_mon
  );
endinterface

// File: rtl/amp_seq.sv
// Amplifier power-up/shutdown sequencer: orders enable, I2S clock gating and mute,
// with a synchronised fault input that forces safe outputs.
`timescale 1ns/1ps
module amp_seq #(
  parameter int unsigned TICK_DIV = 12000,
  parameter int unsigned T_EN     = 10,
  parameter int unsigned T_CLK    = 5,
  parameter int unsigned T_MUTE   = 5
) (
  input  logic      clk,
  input  logic      resetb,
  amp_seq_if.slave  bus
);

  localparam logic [15:0] DIV_M1  = 16'(TICK_DIV - 1);
  localparam logic [7:0]  EN_W    = 8'(T_EN);
  localparam logic [7:0]  CLK_W   = 8'(T_CLK);
  localparam logic [7:0]  MUTE_W  = 8'(T_MUTE);

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_PWRUP = 3'd1,
    S_CLKUP = 3'd2,
    S_PLAY  = 3'd3,
    S_MUTE  = 3'd4,
    S_CLKDN = 3'd5,
    S_FAULT = 3'd7
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        fault_meta;
  logic        sync_fault;
  logic [15:0] pre_cnt;
  logic [7:0]  tick_cnt;
  logic        req;
  logic [7:0]  dwell;
  logic        done;
  logic        nen_nxt;
  logic        mute_nxt;
  logic        clk_en_nxt;

  assign req = bus.start & bus.ena;

  // Dwell length of the current timed state, in ticks.
  always_comb begin
    dwell = EN_W;
    case (state)
      S_CLKUP: dwell = CLK_W;
      S_MUTE:  dwell = MUTE_W;
      default: dwell = EN_W;
    endcase
  end

  // Last cycle of the dwell: final prescaler count of the final tick.
  assign done = (pre_cnt == DIV_M1) && (tick_cnt == (dwell - 8'd1));

  // Next-state logic; a synchronised fault overrides everything else.
  always_comb begin
    state_nxt = state;
    if (sync_fault) begin
      state_nxt = S_FAULT;
    end else begin
      case (state)
        S_OFF:   if (req) state_nxt = S_PWRUP;
        S_PWRUP: if (!req) state_nxt = S_OFF;   else if (done) state_nxt = S_CLKUP;
        S_CLKUP: if (!req) state_nxt = S_CLKDN; else if (done) state_nxt = S_PLAY;
        S_PLAY:  if (!req) state_nxt = S_MUTE;
        S_MUTE:  if (done) state_nxt = S_CLKDN;
        S_CLKDN: if (done) state_nxt = S_OFF;
        S_FAULT: if (!req) state_nxt = S_OFF;
        default: state_nxt = S_OFF;
      endcase
    end
  end

  // Output decode of the upcoming state so the registered outputs track the state register.
  always_comb begin
    nen_nxt    = 1'b1;
    mute_nxt   = 1'b1;
    clk_en_nxt = 1'b0;
    case (state_nxt)
      S_PWRUP: nen_nxt = 1'b0;
      S_CLKUP, S_MUTE: begin
        nen_nxt    = 1'b0;
        clk_en_nxt = 1'b1;
      end
      S_PLAY: begin
        nen_nxt    = 1'b0;
        mute_nxt   = 1'b0;
        clk_en_nxt = 1'b1;
      end
      S_CLKDN: nen_nxt = 1'b0;
      default: begin
        nen_nxt    = 1'b1;
        mute_nxt   = 1'b1;
        clk_en_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state           <= S_OFF;
      fault_meta      <= 1'b0;
      sync_fault      <= 1'b0;
      pre_cnt         <= 16'd0;
      tick_cnt        <= 8'd0;
      bus.amp_nenable <= 1'b1;
      bus.amp_mute    <= 1'b1;
      bus.i2s_clk_en  <= 1'b0;
      bus.ready       <= 1'b0;
      bus.state_mon   <= 3'd0;
    end else begin
      fault_meta      <= bus.fault;
      sync_fault      <= fault_meta;
      state           <= state_nxt;
      bus.amp_nenable <= nen_nxt;
      bus.amp_mute    <= mute_nxt;
      bus.i2s_clk_en  <= clk_en_nxt;
      bus.ready       <= (state_nxt == S_PLAY);
      bus.state_mon   <= 3'(state_nxt);
      // Timer restarts on every state entry; both counters saturate instead of wrapping.
      if (state_nxt != state) begin
        pre_cnt  <= 16'd0;
        tick_cnt <= 8'd0;
      end else if (pre_cnt >= DIV_M1) begin
        pre_cnt  <= 16'd0;
        if (tick_cnt != 8'hFF) tick_cnt <= tick_cnt + 8'd1;
      end else if (pre_cnt != 16'hFFFF) begin
        pre_cnt  <= pre_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_amp_seq.sv
// Directed bench for amp_seq: table-driven power-up/shutdown plus abort, fault,
// ena and reset corner sequences with hand-computed expectations.
`timescale 1ns/1ps
module tb_amp_seq;

  logic clk;
  logic resetb;
  int   checks;
  int   failures;

  amp_seq_if bus ();

  amp_seq #(
    .TICK_DIV (4),
    .T_EN     (3),
    .T_CLK    (2),
    .T_MUTE   (2)
  ) dut (
    .clk    (clk),
    .resetb (resetb),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned n;
    logic        start;
    logic        ena;
    logic [2:0]  st;
    logic        nen;
    logic        mute;
    logic        ck;
    logic        rdy;
  } vec_t;

  vec_t vecs [12];

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [2:0] st, input logic nen,
                       input logic mute, input logic ck, input logic rdy);
    checks++;
    if ({bus.state_mon, bus.amp_nenable, bus.amp_mute, bus.i2s_clk_en, bus.ready}
        !== {st, nen, mute, ck, rdy}) begin
      failures++;
      $display("FAIL %s: got st=%0d nen=%b mute=%b clk_en=%b ready=%b, want st=%0d nen=%b mute=%b clk_en=%b ready=%b",
               name, bus.state_mon, bus.amp_nenable, bus.amp_mute, bus.i2s_clk_en, bus.ready,
               st, nen, mute, ck, rdy);
    end
  endtask

  // Expected outputs per state from the decode table.
  task automatic check_st(input string name, input logic [2:0] st);
    case (st)
      3'd1:       check(name, st, 1'b0, 1'b1, 1'b0, 1'b0);
      3'd2, 3'd4: check(name, st, 1'b0, 1'b1, 1'b1, 1'b0);
      3'd3:       check(name, st, 1'b0, 1'b0, 1'b1, 1'b1);
      3'd5:       check(name, st, 1'b0, 1'b1, 1'b0, 1'b0);
      default:    check(name, st, 1'b1, 1'b1, 1'b0, 1'b0);
    endcase
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    resetb    = 1'b0;
    bus.start = 1'b0;
    bus.ena   = 1'b0;
    bus.fault = 1'b0;

    //            n   start ena  st    nen  mute clk  rdy
    vecs[0]  = '{ 3,  1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{ 1,  1'b1, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{11,  1'b1, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{ 1,  1'b1, 1'b1, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{ 7,  1'b1, 1'b1, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{ 1,  1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{ 5,  1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{ 1,  1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{ 7,  1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{ 1,  1'b0, 1'b1, 3'd5, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{11,  1'b0, 1'b1, 3'd5, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{ 1,  1'b0, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0};

    tick(2);
    check("reset_state", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    resetb = 1'b1;

    // Power-up and orderly shutdown with dwell boundaries.
    for (int i = 0; i < 12; i++) begin
      bus.start = vecs[i].start;
      bus.ena   = vecs[i].ena;
      tick(vecs[i].n);
      check($sformatf("vec%0d", i), vecs[i].st, vecs[i].nen, vecs[i].mute, vecs[i].ck, vecs[i].rdy);
    end

    // Abort during PWRUP.
    bus.start = 1'b1;
    tick(1);  check_st("abort_pwrup_entry", 3'd1);
    tick(4);  check_st("abort_pwrup_mid", 3'd1);
    bus.start = 1'b0;
    tick(1);  check_st("abort_pwrup_off", 3'd0);

    // Abort during CLKUP; a new request during CLKDN waits for OFF.
    bus.start = 1'b1;
    tick(13); check_st("abort_clkup_in", 3'd2);
    bus.start = 1'b0;
    tick(1);  check_st("abort_clkup_clkdn", 3'd5);
    bus.start = 1'b1;
    tick(11); check_st("clkdn_ignores_req", 3'd5);
    tick(1);  check_st("clkdn_off", 3'd0);
    tick(1);  check_st("off_to_pwrup", 3'd1);
    bus.start = 1'b0;
    tick(1);  check_st("pwrup_drop", 3'd0);

    // One-cycle fault pulse in PLAY.
    bus.start = 1'b1;
    tick(21); check_st("fault_play", 3'd3);
    bus.fault = 1'b1;
    tick(1);
    bus.fault = 1'b0;
    check_st("fault_edge1", 3'd3);
    tick(1);  check_st("fault_edge2", 3'd3);
    tick(1);  check_st("fault_edge3", 3'd7);
    tick(5);  check_st("fault_hold", 3'd7);
    bus.start = 1'b0;
    tick(1);  check_st("fault_exit", 3'd0);

    // ena low in PLAY behaves like start low; req during MUTE is ignored.
    bus.start = 1'b1;
    tick(21); check_st("ena_play", 3'd3);
    bus.ena = 1'b0;
    tick(1);  check_st("ena_mute", 3'd4);
    bus.ena = 1'b1;
    tick(7);  check_st("mute_ignores_req", 3'd4);
    tick(1);  check_st("ena_clkdn", 3'd5);
    tick(11); check_st("ena_clkdn_end", 3'd5);
    tick(1);  check_st("ena_off", 3'd0);
    tick(1);  check_st("ena_repwrup", 3'd1);
    bus.start = 1'b0;
    tick(1);  check_st("ena_drop", 3'd0);

    // Asynchronous reset mid-CLKUP.
    bus.start = 1'b1;
    tick(15); check_st("rst_clkup", 3'd2);
    resetb = 1'b0;
    #2;
    check_st("rst_async", 3'd0);
    tick(1);  check_st("rst_held", 3'd0);
    resetb = 1'b1;
    tick(1);  check_st("rst_release_pwrup", 3'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
